// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage hazard controller; optional perf counters via HAZARD_PERF_CNT_EN
module hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int PERF_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_ex,
  input  logic       ex_is_load,
  input  logic       branch_taken_ex,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_hold,
  output logic       if_id_hold,
  output logic       if_id_flush,
  output logic       id_ex_hold,
  output logic       id_ex_bubble,
  output logic       ex_mem_hold,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_bubble_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_e;

  // Bubbles still owed after the cycle that first sees the hazard.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 3 || PERF_W < 1) begin : g_bad_param
    $error("hazard_ctrl: LOAD_USE_BUBBLES must be 1..3 and PERF_W >= 1");
  end

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mem_stall;
  logic       lu_hit;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign lu_hit    = ex_is_load & (rd_ex != 5'd0) &
                     ((rs1_used & (rs1_id == rd_ex)) | (rs2_used & (rs2_id == rd_ex)));

  // State and bubble counter; async reset aborts any pending bubble sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prioritised control: memory wait freezes everything, then branch flush, then load-use bubbles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (mem_stall) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_hold  = 1'b1;
      ex_mem_hold = 1'b1;
    end else if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = 2'd0;
    end else if (state_q == RUN) begin
      if (lu_hit) begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
        if (LOAD_USE_BUBBLES > 1) begin
          state_d = BUBBLE;
          cnt_d   = CNT_INIT;
        end
      end
    end else begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      if (cnt_q == 2'd1) begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  assign busy = (state_q == BUBBLE) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_bubble_q, perf_flush_q;

  // Event counters; bubbles caused by a branch flush are not counted as load-use bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (mem_stall)
        perf_stall_q <= perf_stall_q + PERF_W'(1);
      if (id_ex_bubble & ~branch_taken_ex)
        perf_bubble_q <= perf_bubble_q + PERF_W'(1);
      if (if_id_flush)
        perf_flush_q <= perf_flush_q + PERF_W'(1);
    end
  end

  assign perf_stall_cyc  = perf_stall_q;
  assign perf_bubble_cyc = perf_bubble_q;
  assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the in-order 5-stage RV32I core.
- Drives the hold, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. Its id_ex_bubble output is the stall input of the ID/EX register, which zeroes that register.
- Detects load-use hazards and inserts a configurable number of bubbles. Freezes the whole pipe on data-memory wait and flushes wrong-path instructions on a taken branch.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rs1_id  input  5  rs1 of the instruction in ID
- rs2_id  input  5  rs2 of the instruction in ID
- rs1_used  input  1  instruction in ID reads rs1
- rs2_used  input  1  instruction in ID reads rs2
- rd_ex  input  5  destination of the instruction in EX
- ex_is_load  input  1  instruction in EX is a load
- branch_taken_ex  input  1  taken branch or jump resolved in EX
- dmem_req  input  1  MEM stage has an active data-memory access
- dmem_ready  input  1  data memory completes the access this cycle
- pc_hold  output  1  PC keeps its value
- if_id_hold  output  1  IF/ID keeps its value
- if_id_flush  output  1  IF/ID loads a NOP
- id_ex_hold  output  1  ID/EX keeps its value
- id_ex_bubble  output  1  ID/EX loads zeros (bubble)
- ex_mem_hold  output  1  EX/MEM keeps its value
- busy  output  1  FSM is in the BUBBLE state

Behaviour:
- Internal signals:
  - mem_stall = dmem_req & ~dmem_ready.
  - lu_hit = ex_is_load & (rd_ex != 0) & ((rs1_used & rs1_id == rd_ex) | (rs2_used & rs2_id == rd_ex)).
- Registered state: FSM state (RUN, BUBBLE) and a 2-bit count cnt. Both reset to RUN / 0.
- All outputs are combinational from state and inputs. While rst is high, every output is 0.
- Outputs not named in a case below are 0 in that cycle.
- Priority is evaluated every cycle: mem_stall first, then branch_taken_ex, then load-use/BUBBLE.
- mem_stall (any state):
  - pc_hold, if_id_hold, id_ex_hold and ex_mem_hold are 1.
  - id_ex_bubble and if_id_flush are 0.
  - state and cnt are frozen.
- Else branch_taken_ex:
  - if_id_flush and id_ex_bubble are 1; no holds.
  - Next state is RUN and cnt is cleared. A pending BUBBLE is aborted.
- Else RUN with lu_hit:
  - pc_hold, if_id_hold and id_ex_bubble are 1.
  - If LOAD_USE_BUBBLES > 1: next state is BUBBLE with cnt = LOAD_USE_BUBBLES-1. Otherwise stay in RUN.
- Else BUBBLE:
  - pc_hold, if_id_hold and id_ex_bubble are 1. lu_hit is not re-evaluated.
  - cnt decrements each cycle. When cnt == 1 at the clock edge, next state is RUN and cnt becomes 0.
- Else RUN without a hit: all outputs 0.
- busy = (state == BUBBLE), independent of mem_stall.
- Load-use latency:
  - The dependent instruction leaves ID exactly LOAD_USE_BUBBLES non-mem-stalled cycles after lu_hit is first seen.
  - Mem-stall cycles extend this 1:1.
- rd_ex == 0 never produces a hazard.
- A load followed by a load-use in back-to-back instructions is detected again after release. Each hazard receives the full bubble count.
- Asynchronous reset mid-BUBBLE returns the FSM to RUN/0 immediately. Outputs go to 0 during reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add three outputs, each PERF_W bits:
  - perf_stall_cyc: +1 each cycle with mem_stall.
  - perf_bubble_cyc: +1 each cycle id_ex_bubble is 1 and branch_taken_ex is 0.
  - perf_flush_cnt: +1 each cycle if_id_flush is 1.
- Counter behaviour: wrap at 2^PERF_W, clear on rst, increment only while rst is low.
- When the macro is undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- LOAD_USE_BUBBLES=1; ex_is_load=1, rd_ex=5, rs1_id=5, rs1_used=1 for one cycle, then EX holds a bubble -> exactly 1 cycle of pc_hold=if_id_hold=id_ex_bubble=1; busy stays 0.
- LOAD_USE_BUBBLES=2; same hazard on rs2 (rs2_id=5) -> 2 consecutive bubble cycles; busy=1 in the 2nd; cnt goes 1->0, then RUN.
- rd_ex=0, ex_is_load=1, rs1_id=0, rs1_used=1 -> no outputs asserted. rs1_used=0 with matching rs1_id -> no hazard.
- LOAD_USE_BUBBLES=3; hazard, then dmem_req=1/dmem_ready=0 for 4 cycles during the 2nd bubble:
  - 4 cycles of all four holds with id_ex_bubble=0;
  - then the remaining 2 bubble cycles;
  - total 7 cycles before the dependent instruction leaves ID.
- branch_taken_ex=1 concurrent with lu_hit -> if_id_flush=id_ex_bubble=1, pc_hold=0, state RUN. Concurrent with mem_stall -> holds only, no flush.
- rst pulse in BUBBLE state -> outputs 0 immediately, busy=0. With HAZARD_PERF_CNT_EN, all counters read 0 afterwards.
